// File: rtl/aiken_dec_checker_if.sv
// aiken_dec_checker_if
//   Beat-level bus between the Aiken decade-count source, the checker and
//   the BCD consumer.
//   master : source/consumer side (drives in_*, observes the results)
//   slave  : checker side (samples in_*, drives the results)
//   in_valid/in_code  : one Aiken 2421 digit per valid beat, no back-pressure
//   out_valid/out_bcd : decoded legal digit (out_bcd holds between beats)
//   code_err/seq_err/wrap : single-cycle event pulses
//   locked            : sequence checker is locked to the up-count
//   err_cnt           : saturating error event counter, ERR_W bits
interface aiken_dec_checker_if #(
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic [3:0]       in_code;
  logic             out_valid;
  logic [3:0]       out_bcd;
  logic             code_err;
  logic             seq_err;
  logic             wrap;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output in_valid, in_code,
    input  out_valid, out_bcd, code_err, seq_err, wrap, locked, err_cnt
  );

  modport slave (
    input  in_valid, in_code,
    output out_valid, out_bcd, code_err, seq_err, wrap, locked, err_cnt
  );
endinterface

// File: rtl/aiken_dec_checker.sv
// aiken_dec_checker
//   Receive end of the Aiken (2-4-2-1) decade-count stream. Each valid beat
//   is decoded to BCD; illegal codes are flagged. With AIKEN_SEQ_CHK_EN
//   defined, a HUNT/SYNC/LOCKED tracker also checks that legal digits form a
//   mod-10 up-count, locks after LOCK_CNT correct successors and reports
//   breaks (seq_err) and 9->0 rollovers (wrap). Without the macro the tracker
//   is not built and seq_err/wrap/locked are tied low.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : aiken_dec_checker_if.slave (in_valid/in_code in, results out)
//   All outputs are registered; a beat sampled at edge N shows up after N.
//   Parameters: LOCK_CNT (1..15) successors to lock, ERR_W err_cnt width.
module aiken_dec_checker #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  aiken_dec_checker_if.slave bus
);

  // ---------------------------------------------------------------------
  // Decode: legal codes are 0000..0100 (0..4) and 1011..1111 (5..9).
  // ---------------------------------------------------------------------
  logic       dec_ok;
  logic [3:0] dec_bcd;

  always_comb begin
    dec_ok  = 1'b1;
    dec_bcd = 4'd0;
    case (bus.in_code)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: dec_bcd = bus.in_code;
      4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111: dec_bcd = bus.in_code - 4'd6;
      default:                                     dec_ok  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registered outputs common to both builds
  // ---------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_bcd_q,   out_bcd_d;
  logic             code_err_q,  code_err_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
  logic             err_inc;

`ifdef AIKEN_SEQ_CHK_EN
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_t     state_q, state_d;
  logic [3:0] ref_q,   ref_d;
  logic [3:0] scnt_q,  scnt_d;
  logic       seq_err_q, seq_err_d;
  logic       wrap_q,    wrap_d;
  logic       locked_q;
  logic [3:0] succ;
  logic       is_succ;

  assign succ    = (ref_q == 4'd9) ? 4'd0 : ref_q + 4'd1;
  assign is_succ = (dec_bcd == succ);
`endif

  always_comb begin
    out_valid_d = 1'b0;
    code_err_d  = 1'b0;
    out_bcd_d   = out_bcd_q;
    err_inc     = 1'b0;
`ifdef AIKEN_SEQ_CHK_EN
    seq_err_d   = 1'b0;
    wrap_d      = 1'b0;
    state_d     = state_q;
    ref_d       = ref_q;
    scnt_d      = scnt_q;
`endif
    if (bus.in_valid) begin
      if (!dec_ok) begin
        code_err_d = 1'b1;
        err_inc    = 1'b1;
`ifdef AIKEN_SEQ_CHK_EN
        // An illegal code breaks any sequence: start hunting from scratch.
        state_d    = HUNT;
        ref_d      = 4'd0;
        scnt_d     = 4'd0;
`endif
      end else begin
        out_valid_d = 1'b1;
        out_bcd_d   = dec_bcd;
`ifdef AIKEN_SEQ_CHK_EN
        ref_d       = dec_bcd;
        case (state_q)
          HUNT: begin
            scnt_d  = 4'd0;
            state_d = SYNC;
          end
          SYNC: begin
            if (is_succ) begin
              if (scnt_q + 4'd1 == LOCK_TGT) state_d = LOCKED;
              else                           scnt_d  = scnt_q + 4'd1;
            end else begin
              scnt_d = 4'd0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              wrap_d = (ref_q == 4'd9);
            end else begin
              seq_err_d = 1'b1;
              err_inc   = 1'b1;
              state_d   = SYNC;
              scnt_d    = 4'd0;
            end
          end
          default: begin
            state_d = HUNT;
            scnt_d  = 4'd0;
          end
        endcase
`endif
      end
    end
    // Saturating counter; pulses above still fire when it is pinned.
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bcd_q   <= 4'd0;
      code_err_q  <= 1'b0;
      err_cnt_q   <= '0;
`ifdef AIKEN_SEQ_CHK_EN
      state_q     <= HUNT;
      ref_q       <= 4'd0;
      scnt_q      <= 4'd0;
      seq_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      locked_q    <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      code_err_q  <= code_err_d;
      err_cnt_q   <= err_cnt_d;
`ifdef AIKEN_SEQ_CHK_EN
      state_q     <= state_d;
      ref_q       <= ref_d;
      scnt_q      <= scnt_d;
      seq_err_q   <= seq_err_d;
      wrap_q      <= wrap_d;
      // Taken from next-state so locked rises right after the locking beat.
      locked_q    <= (state_d == LOCKED);
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_bcd   = out_bcd_q;
  assign bus.code_err  = code_err_q;
  assign bus.err_cnt   = err_cnt_q;
`ifdef AIKEN_SEQ_CHK_EN
  assign bus.seq_err   = seq_err_q;
  assign bus.wrap      = wrap_q;
  assign bus.locked    = locked_q;
`else
  assign bus.seq_err   = 1'b0;
  assign bus.wrap      = 1'b0;
  assign bus.locked    = 1'b0;
`endif

endmodule

// File: tb/tb_aiken_dec_checker.sv
// tb_aiken_dec_checker
//   Two checkers (ERR_W=8 and ERR_W=2) share one stimulus stream: directed
//   sequences followed by random beats, gaps, illegal codes and resets. A
//   digit-level reference model predicts every output each cycle. Follows
//   AIKEN_SEQ_CHK_EN the same way the design does.
module tb_aiken_dec_checker;
  localparam int LOCK_CNT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aiken_dec_checker_if #(.ERR_W(8)) bus_a ();
  aiken_dec_checker_if #(.ERR_W(2)) bus_b ();

  aiken_dec_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  aiken_dec_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int enc [10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};

  // reference model state
  int m_bcd, m_cnt_a, m_cnt_b, m_ref, m_run;
  bit m_have, m_lk;
  bit e_ov, e_ce, e_se, e_wr;
  int ce_pulses;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int decode(input int code);
    for (int i = 0; i < 10; i++) if (enc[i] == code) return i;
    return -1;
  endfunction

  task automatic model(input bit v, input int code, input bit r);
    int d;
    e_ov = 0; e_ce = 0; e_se = 0; e_wr = 0;
    if (r) begin
      m_bcd = 0; m_cnt_a = 0; m_cnt_b = 0;
      m_have = 0; m_run = 0; m_lk = 0; m_ref = 0;
    end else if (v) begin
      d = decode(code);
      if (d < 0) begin
        e_ce = 1;
        m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
        m_cnt_b = (m_cnt_b < 3)   ? m_cnt_b + 1 : 3;
        m_have = 0; m_run = 0; m_lk = 0;
      end else begin
        e_ov = 1;
        m_bcd = d;
`ifdef AIKEN_SEQ_CHK_EN
        if (!m_have) begin
          m_have = 1; m_run = 0; m_lk = 0;
        end else if (d == (m_ref + 1) % 10) begin
          if (m_lk) e_wr = (m_ref == 9);
          else begin
            m_run++;
            if (m_run == LOCK_CNT) m_lk = 1;
          end
        end else begin
          if (m_lk) begin
            e_se = 1;
            m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
            m_cnt_b = (m_cnt_b < 3)   ? m_cnt_b + 1 : 3;
          end
          m_lk = 0; m_run = 0;
        end
        m_ref = d;
`endif
      end
    end
  endtask

  task automatic cycle(input bit v, input int code, input bit r);
    rst            = r;
    bus_a.in_valid = v;  bus_a.in_code = 4'(code);
    bus_b.in_valid = v;  bus_b.in_code = 4'(code);
    @(posedge clk);
    #1;
    cyc++;
    model(v, code, r);
    if (bus_a.code_err) ce_pulses++;
    chk("out_valid", int'(bus_a.out_valid), int'(e_ov));
    chk("out_bcd",   int'(bus_a.out_bcd),   m_bcd);
    chk("code_err",  int'(bus_a.code_err),  int'(e_ce));
    chk("seq_err",   int'(bus_a.seq_err),   int'(e_se));
    chk("wrap",      int'(bus_a.wrap),      int'(e_wr));
    chk("locked",    int'(bus_a.locked),    int'(m_lk));
    chk("err_cnt",   int'(bus_a.err_cnt),   m_cnt_a);
    chk("b_code_err", int'(bus_b.code_err), int'(e_ce));
    chk("b_out_bcd",  int'(bus_b.out_bcd),  m_bcd);
    chk("b_err_cnt",  int'(bus_b.err_cnt),  m_cnt_b);
  endtask

  task automatic dig(input int d);
    cycle(1'b1, enc[d], 1'b0);
  endtask

  initial begin
    int cur, r, pre;
    bus_a.in_valid = 0; bus_a.in_code = 0;
    bus_b.in_valid = 0; bus_b.in_code = 0;
    m_bcd = 0; m_cnt_a = 0; m_cnt_b = 0; m_ref = 0; m_run = 0;
    m_have = 0; m_lk = 0; ce_pulses = 0;

    // reset with in_valid high: reset must win
    cycle(1'b1, 4'b1111, 1'b1);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);

    // all 16 codes: 10 decode, 6 are illegal
    for (int c = 0; c < 16; c++) cycle(1'b1, c, 1'b0);
    chk("err_cnt_after16", int'(bus_a.err_cnt), 6);
    cycle(1'b0, 0, 1'b1);

    // lock on 0..4, then roll 5..9,0 for wrap
    for (int d = 0; d < 10; d++) dig(d);
    dig(0);
    // break: 3 then 5, then relock on 6,7,8,9
    dig(3); dig(5);
    dig(6); dig(7); dig(8); dig(9);

    // saturation on the narrow counter
    cycle(1'b0, 0, 1'b1);
    pre = ce_pulses;
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0101 + i, 1'b0);
    chk("code_err_pulses", ce_pulses - pre, 5);
    chk("err_cnt_sat", int'(bus_b.err_cnt), 3);

    // reset while locked with in_valid=1, then 4,5
    for (int d = 0; d < 5; d++) dig(d);
    cycle(1'b1, enc[5], 1'b1);
    dig(4); dig(5);

    // random phase
    cur = 5;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       cycle(1'b1, $urandom_range(0, 15), 1'b1);
      else if (r < 14) cycle(1'b0, $urandom_range(0, 15), 1'b0);
      else if (r < 20) cycle(1'b1, $urandom_range(0, 15), 1'b0);
      else if (r < 24) begin
        cur = $urandom_range(0, 9);
        dig(cur);
      end else begin
        cur = (cur + 1) % 10;
        dig(cur);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
